// File: rtl/sig_gen_sweep_ctrl.sv
// sig_gen_sweep_ctrl
// ------------------
// Frequency-sweep sequencer for the NCO sine/cosine generator. It steps a
// phase-increment word from f_start to f_stop (inclusive) in f_step
// increments and holds each frequency for dwell+2 clock cycles. Sweeps run
// either single-shot or continuously, with an auto-restart at f_start after
// f_stop is passed. Every sweep start issues a phase_rst strobe.
//
// Ports:
//   clk            generator clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          level-sampled sweep request, honoured only in IDLE
//   abort          ends an active sweep on the next edge
//   continuous     restart after f_stop instead of finishing (read live at STEP)
//   f_start        first phase increment            (latched at sweep start)
//   f_stop         last permitted phase increment   (latched at sweep start)
//   f_step         unsigned step added per frequency (latched at sweep start)
//   dwell          hold length, frequency lasts dwell+2 cycles (latched)
//   phase_inc      phase increment to the generator (registered)
//   phase_inc_vld  pulse in the first cycle a new phase_inc is visible
//   phase_rst      pulse alongside phase_inc_vld whenever f_start is loaded
//   busy           high in every state except IDLE
//   done           pulse on normal completion of a single-shot sweep
//   cfg_err        pulse when start is rejected because of a bad config
module sig_gen_sweep_ctrl #(
  parameter int PW = 32,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          continuous,
  input  logic [PW-1:0] f_start,
  input  logic [PW-1:0] f_stop,
  input  logic [PW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  output logic [PW-1:0] phase_inc,
  output logic          phase_inc_vld,
  output logic          phase_rst,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DWELL = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q;
  logic [PW-1:0] f_start_q;
  logic [PW-1:0] f_stop_q;
  logic [PW-1:0] f_step_q;
  logic [DW-1:0] dwell_q;
  logic [DW-1:0] cnt_q;
  logic [PW-1:0] phase_inc_q;
  logic          vld_q;
  logic          phase_rst_q;
  logic          busy_q;
  logic          done_q;
  logic          cfg_err_q;

  // One extra bit so an overflow past 2^PW is seen as a carry rather than
  // wrapping around to a small (and apparently legal) increment.
  logic [PW:0]   next_d;
  logic          step_ok_d;
  logic          cfg_ok_d;

  always_comb begin
    next_d    = {1'b0, phase_inc_q} + {1'b0, f_step_q};
    step_ok_d = !next_d[PW] && (next_d[PW-1:0] <= f_stop_q);
    cfg_ok_d  = (f_step != '0) && (f_start <= f_stop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      f_start_q   <= '0;
      f_stop_q    <= '0;
      f_step_q    <= '0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      phase_inc_q <= '0;
      vld_q       <= 1'b0;
      phase_rst_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      // Strobes default low; each is set for exactly one cycle below.
      vld_q       <= 1'b0;
      phase_rst_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;

      // Abort overrides every transition, including the pulses they would issue.
      if (abort && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (cfg_ok_d) begin
                f_start_q <= f_start;
                f_stop_q  <= f_stop;
                f_step_q  <= f_step;
                dwell_q   <= dwell;
                state_q   <= S_LOAD;
                busy_q    <= 1'b1;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            phase_inc_q <= f_start_q;
            vld_q       <= 1'b1;
            phase_rst_q <= 1'b1;
            cnt_q       <= dwell_q;
            state_q     <= S_DWELL;
          end
          S_DWELL: begin
            // Counter starts at dwell, so DWELL spans dwell+1 cycles.
            if (cnt_q == '0) begin
              state_q <= S_STEP;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_STEP: begin
            if (step_ok_d) begin
              phase_inc_q <= next_d[PW-1:0];
              vld_q       <= 1'b1;
              cnt_q       <= dwell_q;
              state_q     <= S_DWELL;
            end else if (continuous) begin
              state_q <= S_LOAD;
            end else begin
              state_q <= S_DONE;
            end
          end
          S_DONE: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign phase_inc     = phase_inc_q;
  assign phase_inc_vld = vld_q;
  assign phase_rst     = phase_rst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;

endmodule
